telemetry_tx: RTL and testbench

Telemetry framer and UART transmitter; the outbound counterpart of the command receiver on `RxD`. On a `send` strobe it snapshots the current pitch, roll, yaw and height words and serializes them as one checksummed 8N1 frame on `TxD` to the ground station. It sits beside the flight-control state machine, which pulses `send` once per control loop when `busy` is low.

---
 rtl/telemetry_tx_pkg.sv | 37 +++
 rtl/telemetry_tx_async_transmitter.sv | 97 +++++++++
 rtl/telemetry_tx.sv | 154 +++++++++++++++
 tb/tb_telemetry_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_tx_pkg.sv
// telemetry_tx_pkg: constants and helpers shared by the telemetry framer and its
// byte serializer.
//   bit_div()     - cycles per bit, rounded to nearest
//   payload_sum() - modulo-256 sum of the four 16-bit telemetry words
//   FRAME_LEN     - bytes per frame (2 headers, 8 payload, 1 checksum)
//   St*           - frame FSM encodings
package telemetry_tx_pkg;

  localparam int unsigned FRAME_LEN = 11;

  localparam logic [7:0] DEFAULT_HDR0 = 8'hAA;
  localparam logic [7:0] DEFAULT_HDR1 = 8'h55;

  typedef logic [1:0] frame_state_t;

  localparam frame_state_t StIdle = 2'd0;
  localparam frame_state_t StSend = 2'd1;
  localparam frame_state_t StWait = 2'd2;
  localparam frame_state_t StFin  = 2'd3;

  // Round-to-nearest divisor; the result must be at least 2.
  function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Sum of the eight payload bytes, wrapping at 256.
  function automatic logic [7:0] payload_sum(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d);
    logic [7:0] s;
    s = a[15:8] + a[7:0];
    s = s + b[15:8] + b[7:0];
    s = s + c[15:8] + c[7:0];
    s = s + d[15:8] + d[7:0];
    return s;
  endfunction

endpackage

// File: rtl/telemetry_tx_async_transmitter.sv
// async_transmitter: single-byte 8N1 UART serializer.
//   clk, rst_n   - clock, asynchronous active-low reset
//   tx_start     - load tx_data and start a byte; accepted while idle or in
//                  the final cycle of the stop bit (gapless streaming)
//   tx_data[7:0] - byte to send, LSB first
//   TxD          - serial line, idle high, driven from a flop
//   tx_busy      - a byte is on the line
//   tx_done      - one-cycle handoff pulse, two cycles before the stop bit ends,
//                  so a one-cycle-latency controller can chain the next byte with
//                  no idle cycles on the line
module async_transmitter
  import telemetry_tx_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BitDiv = bit_div(ClkFrequency, Baud);
  localparam int unsigned CntW   = $clog2(BitDiv);
  localparam logic [CntW-1:0] CntLoad = CntW'(BitDiv - 1);
  localparam logic [3:0] StopBit = 4'd9;  // 0 = start, 1..8 = data, 9 = stop

  logic            busy_q, busy_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            txd_q, txd_d;

  logic bit_end;
  logic stop_end;
  logic load;

  // The baud counter counts down; the cycle with zero is the last one of a bit.
  assign bit_end  = (baud_cnt_q == '0);
  assign stop_end = busy_q && bit_end && (bit_cnt_q == StopBit);
  assign load     = tx_start && (!busy_q || stop_end);

  always_comb begin
    busy_d     = busy_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    data_d     = data_q;
    txd_d      = txd_q;
    if (load) begin
      busy_d     = 1'b1;
      bit_cnt_d  = 4'd0;
      baud_cnt_d = CntLoad;
      data_d     = tx_data;
      txd_d      = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        // Reload at each boundary so bit lengths never drift.
        baud_cnt_d = CntLoad;
        if (bit_cnt_q == StopBit) begin
          busy_d    = 1'b0;
          bit_cnt_d = 4'd0;
          txd_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Value of the bit that starts next: data bits, then the stop bit.
          txd_d     = (bit_cnt_q < 4'd8) ? data_q[bit_cnt_q[2:0]] : 1'b1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
      data_q     <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
    end
  end

  assign TxD     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = busy_q && (bit_cnt_q == StopBit) && (baud_cnt_q == CntW'(1));

endmodule

// File: rtl/telemetry_tx.sv
// telemetry_tx: telemetry framer and UART transmitter.
// On an accepted send it snapshots pitch/roll/yaw/height and sends the 11-byte
// frame HDR0 HDR1 pitch_hi pitch_lo roll_hi roll_lo yaw_hi yaw_lo height_hi
// height_lo CHK as back-to-back 8N1 bytes.
//   clk, rst_n              - clock, asynchronous active-low reset
//   send                    - frame request, accepted while busy is low
//   pitch, roll, yaw, height - 16-bit words, sampled at acceptance
//   TxD                     - serial line, idle high
//   busy                    - frame in progress
//   done                    - one-cycle pulse after the last stop bit
module telemetry_tx
  import telemetry_tx_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter logic [7:0]  HDR0         = DEFAULT_HDR0,
  parameter logic [7:0]  HDR1         = DEFAULT_HDR1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] pitch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  input  logic [15:0] height,
  output logic        TxD,
  output logic        busy,
  output logic        done
);

  frame_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [15:0]  pitch_q, roll_q, yaw_q, height_q;
  logic         latch;

  logic         tx_start;
  logic [7:0]   tx_byte;
  logic [7:0]   chk;
  logic         tx_busy;
  logic         tx_done;

  // Snapshot registers: written only on acceptance, so later input changes
  // cannot leak into a frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pitch_q  <= 16'h0000;
      roll_q   <= 16'h0000;
      yaw_q    <= 16'h0000;
      height_q <= 16'h0000;
    end else if (latch) begin
      pitch_q  <= pitch;
      roll_q   <= roll;
      yaw_q    <= yaw;
      height_q <= height;
    end
  end

  assign chk = payload_sum(pitch_q, roll_q, yaw_q, height_q);

  always_comb begin
    tx_byte = HDR0;
    case (idx_q)
      4'd0:    tx_byte = HDR0;
      4'd1:    tx_byte = HDR1;
      4'd2:    tx_byte = pitch_q[15:8];
      4'd3:    tx_byte = pitch_q[7:0];
      4'd4:    tx_byte = roll_q[15:8];
      4'd5:    tx_byte = roll_q[7:0];
      4'd6:    tx_byte = yaw_q[15:8];
      4'd7:    tx_byte = yaw_q[7:0];
      4'd8:    tx_byte = height_q[15:8];
      4'd9:    tx_byte = height_q[7:0];
      4'd10:   tx_byte = chk;
      default: tx_byte = HDR0;
    endcase
  end

  // Frame FSM. tx_done arrives two cycles before the stop bit ends: WAIT->SEND
  // uses one, and tx_start lands in the stop bit's final cycle, so bytes are
  // gapless. For the last byte, FIN occupies that final cycle and the registered
  // done/busy change becomes visible right after the stop bit completes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    latch    = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (send && !busy_q && !tx_busy) begin
          latch   = 1'b1;
          busy_d  = 1'b1;
          idx_d   = 4'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        tx_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (tx_done) begin
          if (idx_q == 4'(FRAME_LEN - 1)) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StSend;
          end
        end
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  async_transmitter #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_byte),
    .TxD     (TxD),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx. A UART decoder and edge recorder watch TxD; expected
// frames come from a byte-level model of the frame format.
module tb_telemetry_tx;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 3_000_000;
  localparam int BD = 17;  // round(50e6 / 3e6) = round(16.67)
  localparam int FRAME_CYC = 110 * BD;

  logic        clk;
  logic        rst_n;
  logic        send;
  logic [15:0] pitch, roll, yaw, height;
  logic        TxD, busy, done;

  telemetry_tx #(
    .ClkFrequency(CLK_HZ),
    .Baud        (BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send),
    .pitch (pitch),
    .roll  (roll),
    .yaw   (yaw),
    .height(height),
    .TxD   (TxD),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int edges[$];
  logic [7:0] rx_byte;
  logic prev_txd;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    prev_txd = 1'b1;
    forever begin
      @(negedge clk);
      if (TxD !== prev_txd) begin
        edges.push_back(cyc);
        prev_txd = TxD;
      end
    end
  end

  // UART receiver: sample at mid-bit, check start and stop levels.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && TxD === 1'b0) begin
      repeat (BD / 2) @(negedge clk);
      if (TxD !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        rx_byte[i] = TxD;
      end
      repeat (BD) @(negedge clk);
      if (TxD !== 1'b1) ferr++;
      rx_q.push_back(rx_byte);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: headers, payload bytes big-endian per word, sum mod 256.
  task automatic push_frame(input logic [15:0] p, input logic [15:0] r,
                            input logic [15:0] y, input logic [15:0] h);
    logic [7:0] pl[8];
    int s;
    pl = '{p[15:8], p[7:0], r[15:8], r[7:0], y[15:8], y[7:0], h[15:8], h[7:0]};
    s = 0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pl[i]);
      s = s + int'(pl[i]);
    end
    exp_q.push_back(8'(s % 256));
  endtask

  // Number of line transitions the expected byte stream produces from idle.
  function automatic int exp_edges();
    int n;
    logic prev;
    logic [9:0] f;
    n = 0;
    prev = 1'b1;
    foreach (exp_q[k]) begin
      f = {1'b1, exp_q[k], 1'b0};
      for (int b = 0; b < 10; b++) begin
        if (f[b] != prev) n++;
        prev = f[b];
      end
    end
    return n;
  endfunction

  task automatic check_frame(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    int i;
    check({tag, " len"}, rx_q.size(), exp_q.size());
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 8'hxx;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      check($sformatf("%s byte%0d", tag, i), g, e);
      i++;
    end
    rx_q.delete();
    check({tag, " framing"}, ferr, 0);
  endtask

  task automatic start_frame(input logic [15:0] p, input logic [15:0] r,
                             input logic [15:0] y, input logic [15:0] h, output int acc);
    @(negedge clk);
    pitch = p; roll = r; yaw = y; height = h;
    send = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check({tag, " done seen"}, done, 1);
  endtask

  int acc, at, d0, badiv, nexp;
  logic [15:0] wp, wr, wy, wh, bp, br, by, bh;

  initial begin
    rst_n = 1'b0; send = 1'b0;
    pitch = '0; roll = '0; yaw = '0; height = '0;
    repeat (5) @(negedge clk);
    check("reset TxD", TxD, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("idle lines", {TxD, busy, done}, 3'b100);
    end

    // Single directed frame, with bit timing measured on every edge.
    edges.delete(); rx_q.delete(); d0 = done_cnt;
    start_frame(16'h1234, 16'hFFFE, 16'h0001, 16'h03E8, acc);
    @(negedge clk);
    check("busy by N+1", busy, 1);
    check("start bit by N+2", TxD, 0);
    wait_done("single", FRAME_CYC + 20, at);
    check("single latency", (at - acc >= FRAME_CYC - 2) && (at - acc <= FRAME_CYC + 2), 1);
    @(negedge clk);
    check("done one cycle", done, 0);
    check("busy after frame", busy, 0);
    check("single done count", done_cnt - d0, 1);
    push_frame(16'h1234, 16'hFFFE, 16'h0001, 16'h03E8);
    check("single checksum", exp_q[10], 8'h2F);
    nexp = exp_edges();
    check("edge count", edges.size(), nexp);
    badiv = 0;
    for (int i = 1; i < edges.size(); i++)
      if ((edges[i] - edges[i-1]) % BD != 0) badiv++;
    check("bit intervals", badiv, 0);
    check_frame("single");

    // Mid-frame send with changed inputs is ignored; snapshot holds.
    d0 = done_cnt;
    wp = 16'($urandom); wr = 16'($urandom); wy = 16'($urandom); wh = 16'($urandom);
    start_frame(wp, wr, wy, wh, acc);
    repeat (30 * BD) @(negedge clk);
    pitch = 16'hAAAA; roll = 16'hAAAA; yaw = 16'hAAAA; height = 16'hAAAA;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done("ignore", FRAME_CYC + 20, at);
    repeat (3) @(negedge clk);
    push_frame(wp, wr, wy, wh);
    check_frame("ignore");
    repeat (300) @(negedge clk);
    check("ignore no 2nd done", done_cnt - d0, 1);
    check("ignore no 2nd bytes", rx_q.size(), 0);
    check("ignore idle busy", busy, 0);

    // Back-to-back: send held high across two frames.
    d0 = done_cnt;
    wp = 16'($urandom); wr = 16'($urandom); wy = 16'($urandom); wh = 16'($urandom);
    bp = 16'($urandom); br = 16'($urandom); by = 16'($urandom); bh = 16'($urandom);
    @(negedge clk);
    pitch = wp; roll = wr; yaw = wy; height = wh;
    send = 1'b1;
    @(negedge clk);
    pitch = bp; roll = br; yaw = by; height = bh;
    wait_done("b2b first", FRAME_CYC + 20, at);
    check("b2b busy low in done", busy, 0);
    @(negedge clk);
    send = 1'b0;
    check("b2b accepted in done", busy, 1);
    @(negedge clk);
    check("b2b start within 2", TxD, 0);
    wait_done("b2b second", FRAME_CYC + 20, at);
    repeat (3) @(negedge clk);
    check("b2b done count", done_cnt - d0, 2);
    push_frame(wp, wr, wy, wh);
    push_frame(bp, br, by, bh);
    check_frame("b2b");

    // Reset during byte 5.
    wp = 16'($urandom); wr = 16'($urandom); wy = 16'($urandom); wh = 16'($urandom);
    start_frame(wp, wr, wy, wh, acc);
    repeat (54 * BD) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midreset TxD", TxD, 1);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midreset no done", done_cnt - d0, 0);
    check("midreset idle", {TxD, busy}, 2'b10);
    rx_q.delete(); ferr = 0;
    wp = 16'($urandom); wr = 16'($urandom); wy = 16'($urandom); wh = 16'($urandom);
    start_frame(wp, wr, wy, wh, acc);
    wait_done("postreset", FRAME_CYC + 20, at);
    check("postreset latency", (at - acc >= FRAME_CYC - 2) && (at - acc <= FRAME_CYC + 2), 1);
    repeat (3) @(negedge clk);
    push_frame(wp, wr, wy, wh);
    check_frame("postreset");

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      wp = 16'($urandom); wr = 16'($urandom); wy = 16'($urandom); wh = 16'($urandom);
      start_frame(wp, wr, wy, wh, acc);
      wait_done("random", FRAME_CYC + 20, at);
      repeat (3) @(negedge clk);
      push_frame(wp, wr, wy, wh);
      check_frame($sformatf("random%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
